// File: rtl/stageif_prefetch.sv
// rtl/stageif_prefetch.sv - instruction fetch stage with credit-based prefetch FIFO
module stageif_prefetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_four
);

  localparam int              AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [AW:0]     count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [AW+1:0]   credit;
  logic            req;
  logic            push;
  logic            valid;
  logic            pop;
  logic            redirect_lo_unused;

  assign redirect_lo_unused = ^i_redirect_pc[1:0];

  // Occupancy plus the outstanding response must leave room, so a push never overflows.
  assign credit = {1'b0, count} + {{(AW + 1){1'b0}}, inflight};
  assign req    = i_reset && !i_redirect && (credit < (AW + 2)'(DEPTH));
  assign push   = inflight && !i_redirect;
  assign valid  = (count != '0) && !i_redirect;
  assign pop    = valid && i_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (i_redirect) begin
      fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= i_imem_rdata;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = fetch_pc;
  assign o_valid     = valid;
  assign o_pc        = pc_mem[rd_ptr];
  assign o_pc_four   = pc_mem[rd_ptr] + XLEN'(4);
  assign o_instr     = valid ? instr_mem[rd_ptr] : NOP;

endmodule

// File: tb/tb_stageif_prefetch.sv
// tb/tb_stageif_prefetch.sv - directed self-checking bench for stageif_prefetch
module tb_stageif_prefetch;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;

  int total = 0;
  int bad = 0;
  int nreq;

  stageif_prefetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_instr(o_instr),
    .o_pc(o_pc),
    .o_pc_four(o_pc_four)
  );

  always #5 i_clk = ~i_clk;

  // Always-ready memory: data for the address presented in cycle N is visible in cycle N+1.
  always @(posedge i_clk) i_imem_rdata <= o_imem_addr ^ K;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic restart();
    i_reset = 1'b0;
    i_redirect = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    settle();
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_req", {31'b0, o_imem_req}, 32'd0);
    check("rst_instr", o_instr, NOP);
    check("rst_addr", o_imem_addr, 32'h0);

    // Streaming from reset with decode always ready
    i_ready = 1'b1;
    restart();
    check("s_req0", {31'b0, o_imem_req}, 32'd1);
    check("s_addr0", o_imem_addr, 32'h0);
    check("s_valid0", {31'b0, o_valid}, 32'd0);
    tick();
    check("s_addr1", o_imem_addr, 32'h4);
    check("s_valid1", {31'b0, o_valid}, 32'd0);
    tick();
    check("s_pc_four2", o_pc_four, 32'h4);
    for (int k = 2; k < 8; k++) begin
      check("s_valid", {31'b0, o_valid}, 32'd1);
      check("s_pc", o_pc, 32'(4 * (k - 2)));
      check("s_instr", o_instr, 32'(4 * (k - 2)) ^ K);
      check("s_addr", o_imem_addr, 32'(4 * k));
      tick();
    end

    // Stalled decode fills the FIFO, then drains in order
    i_ready = 1'b0;
    restart();
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_imem_req) begin
        check("f_addr", o_imem_addr, 32'(4 * nreq));
        nreq++;
      end
      tick();
    end
    check("f_nreq", 32'(nreq), 32'd4);
    check("f_req_off", {31'b0, o_imem_req}, 32'd0);
    check("f_valid", {31'b0, o_valid}, 32'd1);
    check("f_pc_held", o_pc, 32'h0);
    i_ready = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      check("d_valid", {31'b0, o_valid}, 32'd1);
      check("d_pc", o_pc, 32'(4 * k));
      check("d_instr", o_instr, 32'(4 * k) ^ K);
      tick();
    end

    // Redirect with three entries queued and one response outstanding
    i_ready = 1'b0;
    restart();
    for (int c = 0; c < 4; c++) tick();
    check("r_credit_full", {31'b0, o_imem_req}, 32'd0);
    check("r_pre_valid", {31'b0, o_valid}, 32'd1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    settle();
    check("r_valid_c0", {31'b0, o_valid}, 32'd0);
    check("r_req_c0", {31'b0, o_imem_req}, 32'd0);
    tick();
    i_redirect = 1'b0;
    settle();
    check("r_valid_c1", {31'b0, o_valid}, 32'd0);
    check("r_addr_c1", o_imem_addr, 32'h100);
    check("r_req_c1", {31'b0, o_imem_req}, 32'd1);
    tick();
    check("r_valid_c2", {31'b0, o_valid}, 32'd0);
    check("r_addr_c2", o_imem_addr, 32'h104);
    tick();
    check("r_valid_c3", {31'b0, o_valid}, 32'd1);
    check("r_pc_c3", o_pc, 32'h100);
    check("r_instr_c3", o_instr, 32'hA5A5_0100);
    i_ready = 1'b1;
    tick();
    check("r_pc_c4", o_pc, 32'h104);

    // Unaligned target, back-to-back redirects, address wrap
    i_redirect = 1'b1;
    i_redirect_pc = 32'h203;
    tick();
    i_redirect = 1'b0;
    settle();
    check("u_addr", o_imem_addr, 32'h200);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h300;
    tick();
    i_redirect_pc = 32'h400;
    tick();
    i_redirect = 1'b0;
    settle();
    check("b_addr", o_imem_addr, 32'h400);
    tick();
    tick();
    check("b_valid", {31'b0, o_valid}, 32'd1);
    check("b_pc", o_pc, 32'h400);
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    settle();
    check("w_addr0", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    check("w_addr1", o_imem_addr, 32'h0);
    tick();
    check("w_pc", o_pc, 32'hFFFF_FFFC);
    check("w_pc_four", o_pc_four, 32'h0);
    check("w_instr", o_instr, 32'h5A5A_FFFC);
    tick();
    check("w_pc_next", o_pc, 32'h0);
    check("w_pc_four_next", o_pc_four, 32'h4);

    // Asynchronous reset mid-stream
    tick();
    tick();
    #2;
    i_reset = 1'b0;
    settle();
    check("a_valid", {31'b0, o_valid}, 32'd0);
    check("a_req", {31'b0, o_imem_req}, 32'd0);
    check("a_instr", o_instr, NOP);
    tick();
    tick();
    i_reset = 1'b1;
    settle();
    check("a_addr0", o_imem_addr, 32'h0);
    check("a_req0", {31'b0, o_imem_req}, 32'd1);
    check("a_valid0", {31'b0, o_valid}, 32'd0);
    tick();
    check("a_valid1", {31'b0, o_valid}, 32'd0);
    tick();
    check("a_valid2", {31'b0, o_valid}, 32'd1);
    check("a_pc2", o_pc, 32'h0);
    check("a_instr2", o_instr, K);
    tick();
    check("a_pc3", o_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
